seven_segment_scanner: RTL

Time-multiplexed driver for a common-anode/common-cathode multi-digit seven-segment display. It latches a packed hex value plus decimal points and scans the digits one at a time at a divided refresh rate. Each digit slot starts with an anti-ghosting guard interval, and leading zeros can optionally be blanked. The block sits between the CPU/debug register file and the board display pins, and replaces the single-digit combinational decoder.

---
 rtl/seven_segment_scanner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display driver: staged/shadowed hex value,
// per-slot anti-ghosting guard, optional leading-zero blanking, registered pins.
module seven_segment_scanner #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1024,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // XOR masks: applying them to an active-high pattern yields pin polarity,
  // and applying them to zero yields the "everything off" pin level.
  localparam logic [6:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_MASK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_stg_val;
  logic [DIGITS-1:0]   r_stg_dp;
  logic [4*DIGITS-1:0] r_shd_val;
  logic [DIGITS-1:0]   r_shd_dp;
  logic [6:0]          r_seg;
  logic                r_seg_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame_done;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [DIGITS-1:0]   w_lz;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    case (n)
      4'h0: seg7_decode = 7'b0111111;
      4'h1: seg7_decode = 7'b0000110;
      4'h2: seg7_decode = 7'b1011011;
      4'h3: seg7_decode = 7'b1001111;
      4'h4: seg7_decode = 7'b1100110;
      4'h5: seg7_decode = 7'b1101101;
      4'h6: seg7_decode = 7'b1111101;
      4'h7: seg7_decode = 7'b0000111;
      4'h8: seg7_decode = 7'b1111111;
      4'h9: seg7_decode = 7'b1101111;
      4'hA: seg7_decode = 7'b1110111;
      4'hB: seg7_decode = 7'b1111100;
      4'hC: seg7_decode = 7'b0111001;
      4'hD: seg7_decode = 7'b1011110;
      4'hE: seg7_decode = 7'b1111001;
      default: seg7_decode = 7'b1110001;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CNT_W'(DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow only moves at frame end so a frame is never torn; a load on that
  // same edge bypasses staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_val <= '0;
      r_stg_dp  <= '0;
      r_shd_val <= '0;
      r_shd_dp  <= '0;
    end else begin
      if (load) begin
        r_stg_val <= value;
        r_stg_dp  <= dp;
      end
      if (w_frame_end) begin
        r_shd_val <= load ? value : r_stg_val;
        r_shd_dp  <= load ? dp    : r_stg_dp;
      end
    end
  end

  // w_lz[i]: shadow nibbles i..DIGITS-1 are all zero.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_shd_val[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_shd_val[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib   = r_shd_val[4*i +: 4];
        w_dp    = r_shd_dp[i];
        w_blank = blank_lz && (i != 0) && w_lz[i];
      end
    end
  end

  assign w_seg = w_blank ? 7'b0000000 : seg7_decode(w_nib);
  assign w_an  = (r_cnt >= CNT_W'(GUARD)) ? (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_MASK;
      r_seg_dp     <= DP_MASK;
      r_an         <= AN_MASK;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg ^ SEG_MASK;
      r_seg_dp     <= w_dp ^ DP_MASK;
      r_an         <= w_an ^ AN_MASK;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign seg_dp     = r_seg_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
